// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - write-back pipeline stage register with valid/ready handshake, halt and flush.
// Define PIPE_SKID_EN for two-entry (main + skid) storage with in_ready taken from state only.
module pipe_stage_reg #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_halt,
    input  logic              in_wen,
    input  logic [ADDR_W-1:0] in_waddr,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_halt,
    output logic              out_wen,
    output logic [ADDR_W-1:0] out_waddr,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        count,
    output logic              halted
);

    localparam int PW = DATA_W + ADDR_W + 2;

    logic [PW-1:0] in_pay;
    logic [PW-1:0] slot0_q, slot0_d;
    logic [1:0]    count_q, count_d;
    logic          halted_q, halted_d;
    logic          push, pop;
    logic          held_wen;

    assign in_pay = {in_halt, in_wen, in_waddr, in_data};
    assign pop    = (count_q != 2'd0) & out_ready;
    assign push   = in_valid & in_ready;

`ifdef PIPE_SKID_EN
    logic [PW-1:0] slot1_q, slot1_d;

    // Depends only on registered state (plus flush/reset), never on out_ready.
    assign in_ready = ~rst_n & (count_q != 2'd2) & ~halted_q & ~flush;

    always_comb begin
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        if (pop) begin
            if (count_q == 2'd2) begin
                slot0_d = slot1_q;
                if (push) slot1_d = in_pay;
            end else if (push) begin
                slot0_d = in_pay;
            end
        end else if (push) begin
            if (count_q == 2'd0) slot0_d = in_pay;
            else                 slot1_d = in_pay;
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) slot1_q <= '0;
        else       slot1_q <= slot1_d;
    end
`else
    // A full single-entry stage can still accept when the head leaves this cycle.
    assign in_ready = ~rst_n & ((count_q == 2'd0) | out_ready) & ~halted_q & ~flush;

    always_comb begin
        slot0_d = slot0_q;
        if (push) slot0_d = in_pay;
    end
`endif

    always_comb begin
        count_d  = count_q + {1'b0, push} - {1'b0, pop};
        halted_d = halted_q | (push & in_halt);
        if (flush) begin
            count_d  = 2'd0;
            halted_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            slot0_q  <= '0;
            count_q  <= 2'd0;
            halted_q <= 1'b0;
        end else begin
            slot0_q  <= slot0_d;
            count_q  <= count_d;
            halted_q <= halted_d;
        end
    end

    assign {out_halt, held_wen, out_waddr, out_data} = slot0_q;
    assign out_valid = (count_q != 2'd0);
    assign out_wen   = held_wen & out_valid;
    assign count     = count_q;
    assign halted    = halted_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - randomized and directed bench for pipe_stage_reg against a queue model.
module tb_pipe_stage_reg;

    typedef struct packed {
        logic        halt;
        logic        wen;
        logic [4:0]  waddr;
        logic [31:0] data;
    } ent_t;

`ifdef PIPE_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, in_halt, in_wen, flush;
    logic [4:0]  in_waddr, out_waddr;
    logic [31:0] in_data, out_data;
    logic        out_valid, out_ready, out_halt, out_wen, halted;
    logic [1:0]  count;

    int   vectors = 0;
    int   miscompares = 0;
    ent_t mq[$];
    logic mhalted = 1'b0;
    bit   check_en = 1'b0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_halt(in_halt), .in_wen(in_wen), .in_waddr(in_waddr), .in_data(in_data),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_halt(out_halt), .out_wen(out_wen), .out_waddr(out_waddr), .out_data(out_data),
        .count(count), .halted(halted)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic exp_ready();
        if (rst_n || flush || mhalted) return 1'b0;
        if (CAP == 2) return mq.size() < 2;
        return (mq.size() == 0) || out_ready;
    endfunction

    function automatic ent_t mk(input logic h, input logic w, input logic [4:0] a, input logic [31:0] d);
        return {h, w, a, d};
    endfunction

    // Reference model: a FIFO of entries with a sticky halt flag.
    always @(posedge clk) begin
        if (!rst_n) begin
            logic r, p;
            r = exp_ready();
            p = (mq.size() != 0) && out_ready;
            if (flush) begin
                mq.delete();
                mhalted = 1'b0;
            end else begin
                if (p) void'(mq.pop_front());
                if (in_valid && r) begin
                    mq.push_back({in_halt, in_wen, in_waddr, in_data});
                    if (in_halt) mhalted = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            logic ev;
            ev = (mq.size() != 0);
            chk("out_valid", out_valid, ev);
            chk("count", count, mq.size());
            chk("in_ready", in_ready, exp_ready());
            chk("halted", halted, mhalted);
            chk("out_wen", out_wen, ev ? mq[0].wen : 1'b0);
            if (ev) begin
                chk("out_data", out_data, mq[0].data);
                chk("out_waddr", out_waddr, mq[0].waddr);
                chk("out_halt", out_halt, mq[0].halt);
            end
        end
    end

    task automatic cycr(input logic v, input ent_t e, input logic ordy, input logic fl, input logic r);
        @(posedge clk);
        #1;
        rst_n = r;
        if (r) begin
            mq.delete();
            mhalted = 1'b0;
        end
        in_valid = v;
        {in_halt, in_wen, in_waddr, in_data} = e;
        out_ready = ordy;
        flush = fl;
        @(negedge clk);
        #1;
    endtask

    task automatic cyc(input logic v, input ent_t e, input logic ordy, input logic fl);
        cycr(v, e, ordy, fl, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; in_halt = 1'b0; in_wen = 1'b0; in_waddr = '0; in_data = '0;
        out_ready = 1'b0; flush = 1'b0;
        #1 rst_n = 1'b1;
        #2;
        chk("rst_count", count, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_halted", halted, 0);
        check_en = 1'b1;
        cycr(0, '0, 0, 0, 1);
        cyc(0, '0, 1, 0);

        // Streaming at one entry per cycle
        for (int k = 0; k < 8; k++) begin
            cyc(1, mk(0, 1, 5'(k), 32'(k + 1)), 1, 0);
            if (k == 0) chk("stream_first_empty", out_valid, 0);
            else begin
                chk("stream_data", out_data, k);
                chk("stream_count", count, 1);
            end
        end
        cyc(0, '0, 1, 0);
        chk("stream_last", out_data, 8);
        cyc(0, '0, 1, 0);
        chk("stream_drained", out_valid, 0);

        // Backpressure
`ifdef PIPE_SKID_EN
        cyc(1, mk(0, 1, 1, 32'hA), 0, 0);
        cyc(1, mk(0, 1, 1, 32'hB), 0, 0);
        chk("bp_count1", count, 1);
        cyc(1, mk(0, 1, 1, 32'hC), 0, 0);
        chk("bp_count2", count, 2);
        chk("bp_full_ready", in_ready, 0);
        cyc(1, mk(0, 1, 1, 32'hC), 1, 0);
        chk("bp_out_a", out_data, 32'hA);
        chk("bp_ready_reg", in_ready, 0);
        cyc(1, mk(0, 1, 1, 32'hC), 1, 0);
        chk("bp_out_b", out_data, 32'hB);
        chk("bp_ready_again", in_ready, 1);
        cyc(0, '0, 1, 0);
        chk("bp_out_c", out_data, 32'hC);
        chk("bp_count_c", count, 1);
`else
        cyc(1, mk(0, 1, 1, 32'hA), 0, 0);
        cyc(1, mk(0, 1, 1, 32'hB), 0, 0);
        chk("bp_full_ready", in_ready, 0);
        chk("bp_out_a", out_data, 32'hA);
        cyc(1, mk(0, 1, 1, 32'hB), 1, 0);
        chk("bp_ready_comb", in_ready, 1);
        cyc(0, '0, 1, 0);
        chk("bp_out_b", out_data, 32'hB);
`endif
        cyc(0, '0, 1, 0);
        chk("bp_drained", out_valid, 0);

        // Halt
        cyc(1, mk(0, 1, 3, 32'h55), 1, 0);
        cyc(1, mk(1, 0, 0, 32'h5A), 1, 0);
        chk("halt_first_data", out_data, 32'h55);
        chk("halt_first_waddr", out_waddr, 3);
        chk("halt_first_wen", out_wen, 1);
        cyc(1, mk(0, 1, 1, 32'h66), 1, 0);
        chk("halt_flag", halted, 1);
        chk("halt_ready", in_ready, 0);
        chk("halt_out_halt", out_halt, 1);
        cyc(1, mk(0, 1, 1, 32'h66), 1, 0);
        chk("halt_no_66", out_valid, 0);
        chk("halt_ready_stays", in_ready, 0);
        cyc(0, '0, 1, 1);
        cyc(0, '0, 1, 0);
        chk("halt_cleared", halted, 0);

        // Flush drops held entries and the concurrent input
        cyc(1, mk(0, 1, 4, 32'h11), 0, 0);
        cyc(1, mk(0, 1, 4, 32'h22), 0, 0);
        cyc(1, mk(0, 1, 4, 32'h77), 0, 1);
        chk("flush_cycle_ready", in_ready, 0);
        chk("flush_count_before", count, CAP);
        cyc(0, '0, 1, 0);
        chk("flush_count", count, 0);
        chk("flush_out_valid", out_valid, 0);
        chk("flush_out_wen", out_wen, 0);

        // Asynchronous reset between edges
        cyc(1, mk(0, 1, 2, 32'h44), 0, 0);
        cyc(0, '0, 0, 0);
        chk("pre_rst_count", count, 1);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        mq.delete();
        mhalted = 1'b0;
        #1;
        chk("async_rst_valid", out_valid, 0);
        chk("async_rst_wen", out_wen, 0);
        chk("async_rst_data", out_data, 0);
        #1;
        rst_n = 1'b0;
        cyc(1, mk(0, 1, 9, 32'h9), 1, 0);
        chk("post_rst_empty", out_valid, 0);
        cyc(0, '0, 1, 0);
        chk("post_rst_data", out_data, 32'h9);
        chk("post_rst_valid", out_valid, 1);

        // Randomized traffic with occasional halt, flush and reset
        for (int i = 0; i < 400; i++) begin
            cycr(($urandom % 4) != 0,
                 mk(($urandom % 25) == 0, 1'($urandom), 5'($urandom), $urandom),
                 ($urandom % 3) != 0, ($urandom % 20) == 0, ($urandom % 60) == 0);
        end
        cyc(0, '0, 1, 1);
        cyc(0, '0, 1, 0);

        check_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 32, the write-back data width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, the register-file write address width in bits.
REQ-003 SHALL have port clk  input  1  the clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  upstream entry present.
REQ-006 SHALL have port in_ready  output  1  stage can accept this cycle.
REQ-007 SHALL have ports in_halt  input  1,  in_wen  input  1,  in_waddr  input  ADDR_W,  in_data  input  DATA_W  forming the upstream payload.
REQ-008 SHALL have port flush  input  1  synchronous discard of all held entries.
REQ-009 SHALL have port out_valid  output  1  downstream entry present.
REQ-010 SHALL have port out_ready  input  1  downstream consumes this cycle.
REQ-011 SHALL have ports out_halt  output  1,  out_wen  output  1,  out_waddr  output  ADDR_W,  out_data  output  DATA_W  forming the downstream payload.
REQ-012 SHALL have port count  output  2  number of held entries (0..2).
REQ-013 SHALL have port halted  output  1  sticky halt-accepted flag.

Function
REQ-014 An entry SHALL be accepted when in_valid & in_ready at a rising edge, and popped when out_valid & out_ready.
REQ-015 Entry order SHALL be strictly FIFO; latency from acceptance into an empty stage to out_valid SHALL be exactly 1 cycle.
REQ-016 out_valid SHALL equal (count != 0); out_* payload SHALL come from the oldest entry.
REQ-017 out_wen SHALL equal the held wen AND out_valid, so a bubble never writes the register file.
REQ-018 Payload registers SHALL NOT be cleared on pop; only valid state changes.
REQ-019 Simultaneous accept and pop SHALL leave count unchanged and sustain one entry per cycle.
REQ-020 Accepting an entry with in_halt=1 SHALL set halted at the same edge; while halted, in_ready SHALL be 0, and held entries SHALL still drain normally.
REQ-021 flush SHALL, at the next edge, set count to 0 and clear halted; any in_valid in that cycle SHALL be dropped even if in_ready=1, and a pop in that cycle still completes downstream.
REQ-022 in_ready SHALL be 0 in the flush cycle.

Reset
REQ-023 While rst_n=1, count, halted, out_valid, out_halt, out_wen SHALL be 0, out_waddr and out_data SHALL be all-zero, and in_ready SHALL be 0.
REQ-024 Reset asserted mid-transfer SHALL discard all entries immediately without waiting for clk; the first edge after release SHALL accept normally.

Configuration
REQ-025 Macro PIPE_SKID_EN defined: two-entry storage (main + skid); in_ready SHALL be registered, equal to (count<2) & ~halted & ~flush from state only, with no combinational path from out_ready.
REQ-026 PIPE_SKID_EN undefined: single entry; in_ready SHALL be ((count==0) | out_ready) & ~halted & ~flush, combinational from out_ready; count SHALL never exceed 1.

Verification
REQ-027 Streaming: in_valid=1 for 8 cycles with data 0x1..0x8, out_ready=1 -> out_data 0x1..0x8 on consecutive cycles, first one cycle after first accept, count stays 1.
REQ-028 Backpressure (PIPE_SKID_EN): out_ready=0, push 0xA,0xB,0xC -> 0xA,0xB accepted, count=2, in_ready=0 for 0xC; raise out_ready -> 0xA,0xB,0xC emerge in order, none lost or duplicated.
REQ-029 Halt: push wen=1,waddr=3,data=0x55 then halt=1 entry then 0x66 -> halted=1 after halt entry, 0x66 never accepted, out_halt=1 on second output, in_ready stays 0.
REQ-030 Flush: count=2, assert flush with in_valid=1 data 0x77 -> next cycle count=0, out_valid=0, out_wen=0, halted=0, 0x77 never appears.
REQ-031 Reset mid-operation: count=1, rst_n=1 between edges -> out_valid, out_wen, out_data drop to 0 before next edge; after release, push 0x9 -> 0x9 out one cycle later.
